// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, single-cycle ALU/branch/MUL, jump target
// generation, and an iterative one-bit-per-cycle restoring divider that stalls
// the front end while it runs.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module stage_ex #(
  parameter int reg_addr_width = `REG_ADDR_WIDTH,
  parameter int mem_addr_width = `MEM_ADDR_WIDTH,
  parameter int word_width     = `WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [mem_addr_width-1:0] pc_in,
  input  logic [word_width-1:0]     rs1_val_in,
  input  logic [word_width-1:0]     rs2_val_in,
  input  logic [reg_addr_width-1:0] rs1_addr_in,
  input  logic [reg_addr_width-1:0] rs2_addr_in,
  input  logic [reg_addr_width-1:0] rd_addr_in,
  input  logic [word_width-1:0]     imm_ext_in,
  input  logic [4:0]                alu_op_in,
  input  logic                      alu_src_in,
  input  logic                      pc_src_in,
  input  logic                      jalr_in,
  input  logic                      jmp_ctl_in,
  input  logic                      bch_ctl_in,
  input  logic                      mem_ctl_in,
  input  logic                      rd_wen_in,
  input  logic [1:0]                wb_ctl_in,
  input  logic [2:0]                byt_typ_in,
  input  logic                      mem_fwd_en,
  input  logic [reg_addr_width-1:0] mem_rd,
  input  logic [word_width-1:0]     mem_fwd_val,
  input  logic                      wb_fwd_en,
  input  logic [reg_addr_width-1:0] wb_rd,
  input  logic [word_width-1:0]     wb_fwd_val,
  input  logic                      flush,
  output logic                      ex_busy,
  output logic [mem_addr_width-1:0] tgt_addr_out,
  output logic [word_width-1:0]     rs2_val_out,
  output logic [word_width-1:0]     rslt_out,
  output logic [word_width-1:0]     imm_ext_out,
  output logic                      jmp_ctl_out,
  output logic                      bch_ctl_out,
  output logic                      mem_ctl_out,
  output logic                      rd_wen_out,
  output logic [1:0]                wb_ctl_out,
  output logic [2:0]                byt_typ_out,
  output logic [reg_addr_width-1:0] rd_addr_out
);

  localparam logic [4:0] op_add  = 5'd0,  op_sub  = 5'd1,  op_sll  = 5'd2,  op_slt  = 5'd3;
  localparam logic [4:0] op_sltu = 5'd4,  op_xor  = 5'd5,  op_srl  = 5'd6,  op_sra  = 5'd7;
  localparam logic [4:0] op_or   = 5'd8,  op_and  = 5'd9,  op_beq  = 5'd10, op_bne  = 5'd11;
  localparam logic [4:0] op_blt  = 5'd12, op_bge  = 5'd13, op_bltu = 5'd14, op_bgeu = 5'd15;
  localparam logic [4:0] op_mul  = 5'd16, op_div  = 5'd17, op_divu = 5'd18, op_rem  = 5'd19;
  localparam logic [4:0] op_remu = 5'd20;

  localparam int cnt_w = $clog2(word_width);
  localparam logic [cnt_w-1:0]          cnt_last_c = cnt_w'(word_width - 1);
  localparam logic [word_width-1:0]     one_c      = word_width'(1'b1);
  localparam logic [word_width-1:0]     four_c     = word_width'(3'd4);
  localparam logic [mem_addr_width-1:0] mem_lsb_c  = mem_addr_width'(1'b1);

  typedef struct packed {
    logic [mem_addr_width-1:0] pc;
    logic [word_width-1:0]     rs1_val;
    logic [word_width-1:0]     rs2_val;
    logic [word_width-1:0]     imm;
    logic [reg_addr_width-1:0] rs1_addr;
    logic [reg_addr_width-1:0] rs2_addr;
    logic [reg_addr_width-1:0] rd_addr;
    logic [4:0]                alu_op;
    logic                      alu_src;
    logic                      pc_src;
    logic                      jalr;
    logic                      jmp;
    logic                      bch;
    logic                      mem;
    logic                      rd_wen;
    logic [1:0]                wb_ctl;
    logic [2:0]                byt_typ;
  } ex_pipe_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} ex_state_t;

  ex_pipe_t                  pipe_r, pipe_in_s;
  ex_state_t                 state_r, state_nxt_s;
  logic [cnt_w-1:0]          cnt_r;
  logic [word_width-1:0]     rs1_fwd_s, rs2_fwd_s, alu_a_s, alu_b_s, alu_rslt_s;
  logic                      lt_s, ltu_s, eq_s;
  logic [word_width-1:0]     jalr_sum_s;
  logic                      div_signed_s, a_neg_s, b_neg_s;
  logic [word_width-1:0]     a_abs_s, b_abs_s, rem_in_s, quo_in_s, dvs_in_s;
  logic [word_width:0]       shifted_s, diff_s;
  logic [word_width-1:0]     rem_nxt_s, quo_nxt_s, q_fin_s, r_fin_s, div_rslt_s;
  logic [word_width-1:0]     rem_r, quo_r, dvs_r, dvd_r;
  logic                      dvz_r, neg_q_r, neg_r_r;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == op_div) || (op == op_divu) || (op == op_rem) || (op == op_remu);
  endfunction

  // Newest producer wins: MEM result is younger than WB; x0 is hard-wired zero.
  function automatic logic [word_width-1:0] fwd_operand(
    input logic [reg_addr_width-1:0] addr,
    input logic [word_width-1:0]     latched
  );
    if (addr == '0)                          return '0;
    else if (mem_fwd_en && (mem_rd == addr)) return mem_fwd_val;
    else if (wb_fwd_en && (wb_rd == addr))   return wb_fwd_val;
    else                                     return latched;
  endfunction

  // Gather the ID-side inputs into one pipeline word.
  always_comb begin
    pipe_in_s = '{pc: pc_in, rs1_val: rs1_val_in, rs2_val: rs2_val_in, imm: imm_ext_in,
                  rs1_addr: rs1_addr_in, rs2_addr: rs2_addr_in, rd_addr: rd_addr_in,
                  alu_op: alu_op_in, alu_src: alu_src_in, pc_src: pc_src_in, jalr: jalr_in,
                  jmp: jmp_ctl_in, bch: bch_ctl_in, mem: mem_ctl_in, rd_wen: rd_wen_in,
                  wb_ctl: wb_ctl_in, byt_typ: byt_typ_in};
  end

  // Pipeline register: reset/flush insert an all-zero bubble, a running divide holds it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_r <= '0;
    end else if (state_r != S_DIV) begin
      pipe_r <= pipe_in_s;
    end else begin
      pipe_r <= pipe_r;
    end
  end

  // Operand selection: forwarding, then PC/immediate muxing.
  always_comb begin
    rs1_fwd_s = fwd_operand(pipe_r.rs1_addr, pipe_r.rs1_val);
    rs2_fwd_s = fwd_operand(pipe_r.rs2_addr, pipe_r.rs2_val);
    if (pipe_r.pc_src) alu_a_s = word_width'(pipe_r.pc);
    else               alu_a_s = rs1_fwd_s;
    if (pipe_r.alu_src) alu_b_s = pipe_r.imm;
    else                alu_b_s = rs2_fwd_s;
  end

  // Single-cycle ALU, compare and multiply results.
  always_comb begin
    lt_s  = $signed(alu_a_s) < $signed(alu_b_s);
    ltu_s = alu_a_s < alu_b_s;
    eq_s  = alu_a_s == alu_b_s;
    case (pipe_r.alu_op)
      op_add:  alu_rslt_s = alu_a_s + alu_b_s;
      op_sub:  alu_rslt_s = alu_a_s - alu_b_s;
      op_sll:  alu_rslt_s = alu_a_s << alu_b_s[4:0];
      op_slt:  alu_rslt_s = {{(word_width-1){1'b0}}, lt_s};
      op_sltu: alu_rslt_s = {{(word_width-1){1'b0}}, ltu_s};
      op_xor:  alu_rslt_s = alu_a_s ^ alu_b_s;
      op_srl:  alu_rslt_s = alu_a_s >> alu_b_s[4:0];
      op_sra:  alu_rslt_s = $unsigned($signed(alu_a_s) >>> alu_b_s[4:0]);
      op_or:   alu_rslt_s = alu_a_s | alu_b_s;
      op_and:  alu_rslt_s = alu_a_s & alu_b_s;
      op_beq:  alu_rslt_s = {{(word_width-1){1'b0}}, eq_s};
      op_bne:  alu_rslt_s = {{(word_width-1){1'b0}}, ~eq_s};
      op_blt:  alu_rslt_s = {{(word_width-1){1'b0}}, lt_s};
      op_bge:  alu_rslt_s = {{(word_width-1){1'b0}}, ~lt_s};
      op_bltu: alu_rslt_s = {{(word_width-1){1'b0}}, ltu_s};
      op_bgeu: alu_rslt_s = {{(word_width-1){1'b0}}, ~ltu_s};
      op_mul:  alu_rslt_s = alu_a_s * alu_b_s;
      default: alu_rslt_s = '0;
    endcase
  end

  // Divider iteration: the first cycle draws magnitudes straight from the operands.
  always_comb begin
    div_signed_s = (pipe_r.alu_op == op_div) || (pipe_r.alu_op == op_rem);
    a_neg_s = div_signed_s & alu_a_s[word_width-1];
    b_neg_s = div_signed_s & alu_b_s[word_width-1];
    if (a_neg_s) a_abs_s = ~alu_a_s + one_c;
    else         a_abs_s = alu_a_s;
    if (b_neg_s) b_abs_s = ~alu_b_s + one_c;
    else         b_abs_s = alu_b_s;
    if (cnt_r == '0) begin
      rem_in_s = '0;
      quo_in_s = a_abs_s;
      dvs_in_s = b_abs_s;
    end else begin
      rem_in_s = rem_r;
      quo_in_s = quo_r;
      dvs_in_s = dvs_r;
    end
    shifted_s = {rem_in_s, quo_in_s[word_width-1]};
    diff_s    = shifted_s - {1'b0, dvs_in_s};
    if (diff_s[word_width]) begin
      rem_nxt_s = shifted_s[word_width-1:0];
      quo_nxt_s = {quo_in_s[word_width-2:0], 1'b0};
    end else begin
      rem_nxt_s = diff_s[word_width-1:0];
      quo_nxt_s = {quo_in_s[word_width-2:0], 1'b1};
    end
  end

  // Divider datapath registers; sign/zero info is latched on the first DIV cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r <= '0; quo_r <= '0; dvs_r <= '0; dvd_r <= '0;
      dvz_r <= 1'b0; neg_q_r <= 1'b0; neg_r_r <= 1'b0;
    end else if (state_r == S_DIV) begin
      rem_r <= rem_nxt_s;
      quo_r <= quo_nxt_s;
      if (cnt_r == '0) begin
        dvs_r   <= b_abs_s;
        dvd_r   <= alu_a_s;
        dvz_r   <= (alu_b_s == '0);
        neg_q_r <= a_neg_s ^ b_neg_s;
        neg_r_r <= a_neg_s;
      end
    end
  end

  // Sign correction and divide-by-zero override of the finished divide.
  always_comb begin
    if (dvz_r)        q_fin_s = '1;
    else if (neg_q_r) q_fin_s = ~quo_r + one_c;
    else              q_fin_s = quo_r;
    if (dvz_r)        r_fin_s = dvd_r;
    else if (neg_r_r) r_fin_s = ~rem_r + one_c;
    else              r_fin_s = rem_r;
    if ((pipe_r.alu_op == op_rem) || (pipe_r.alu_op == op_remu)) div_rslt_s = r_fin_s;
    else                                                          div_rslt_s = q_fin_s;
  end

  // Divider FSM next state; flush aborts any divide.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (is_div_op(alu_op_in)) state_nxt_s = S_DIV;
          else                      state_nxt_s = S_IDLE;
        end
        S_DIV: begin
          if (cnt_r == cnt_last_c) state_nxt_s = S_DONE;
          else                     state_nxt_s = S_DIV;
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // FSM state and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_DIV) && (state_nxt_s == S_DIV)) cnt_r <= cnt_r + 1'b1;
      else                                              cnt_r <= '0;
    end
  end

  // Outputs to MEM; a divide in flight shows as a bubble.
  always_comb begin
    jalr_sum_s = rs1_fwd_s + pipe_r.imm;
    if (pipe_r.jalr) tgt_addr_out = mem_addr_width'(jalr_sum_s) & ~mem_lsb_c;
    else             tgt_addr_out = pipe_r.pc + mem_addr_width'(pipe_r.imm);
    if (state_r == S_DONE) rslt_out = div_rslt_s;
    else if (pipe_r.jmp)   rslt_out = word_width'(pipe_r.pc) + four_c;
    else                   rslt_out = alu_rslt_s;
    ex_busy     = (state_r == S_DIV);
    rs2_val_out = rs2_fwd_s;
    imm_ext_out = pipe_r.imm;
    jmp_ctl_out = pipe_r.jmp    & ~ex_busy;
    bch_ctl_out = pipe_r.bch    & ~ex_busy;
    mem_ctl_out = pipe_r.mem    & ~ex_busy;
    rd_wen_out  = pipe_r.rd_wen & ~ex_busy;
    wb_ctl_out  = pipe_r.wb_ctl;
    byt_typ_out = pipe_r.byt_typ;
    rd_addr_out = pipe_r.rd_addr;
  end

endmodule

// File: tb/tb_stage_ex.sv
// Scoreboard bench for stage_ex: expected results queued at drive time, popped
// when the stage presents them.
module tb_stage_ex;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_DIV = 5'd17, OP_DIVU = 5'd18;
  localparam logic [4:0] OP_REM = 5'd19, OP_REMU = 5'd20;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] pc_in, rs1_val_in, rs2_val_in, imm_ext_in, mem_fwd_val, wb_fwd_val;
  logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in, alu_op_in, mem_rd, wb_rd;
  logic alu_src_in, pc_src_in, jalr_in, jmp_ctl_in, bch_ctl_in, mem_ctl_in, rd_wen_in;
  logic [1:0] wb_ctl_in;
  logic [2:0] byt_typ_in;
  logic mem_fwd_en, wb_fwd_en, flush, ex_busy;
  logic [31:0] tgt_addr_out, rs2_val_out, rslt_out, imm_ext_out;
  logic jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out;
  logic [1:0] wb_ctl_out;
  logic [2:0] byt_typ_out;
  logic [4:0] rd_addr_out;

  typedef struct { string tag; logic [31:0] rslt; } exp_t;
  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_ex #(.reg_addr_width(5), .mem_addr_width(32), .word_width(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .imm_ext_in(imm_ext_in), .alu_op_in(alu_op_in), .alu_src_in(alu_src_in),
    .pc_src_in(pc_src_in), .jalr_in(jalr_in), .jmp_ctl_in(jmp_ctl_in), .bch_ctl_in(bch_ctl_in),
    .mem_ctl_in(mem_ctl_in), .rd_wen_in(rd_wen_in), .wb_ctl_in(wb_ctl_in), .byt_typ_in(byt_typ_in),
    .mem_fwd_en(mem_fwd_en), .mem_rd(mem_rd), .mem_fwd_val(mem_fwd_val),
    .wb_fwd_en(wb_fwd_en), .wb_rd(wb_rd), .wb_fwd_val(wb_fwd_val),
    .flush(flush), .ex_busy(ex_busy), .tgt_addr_out(tgt_addr_out), .rs2_val_out(rs2_val_out),
    .rslt_out(rslt_out), .imm_ext_out(imm_ext_out), .jmp_ctl_out(jmp_ctl_out),
    .bch_ctl_out(bch_ctl_out), .mem_ctl_out(mem_ctl_out), .rd_wen_out(rd_wen_out),
    .wb_ctl_out(wb_ctl_out), .byt_typ_out(byt_typ_out), .rd_addr_out(rd_addr_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {32'd0, rslt_out}, {32'd0, e.rslt});
    end
  endtask

  task automatic clear_inputs();
    pc_in = 32'd0; rs1_val_in = 32'd0; rs2_val_in = 32'd0; imm_ext_in = 32'd0;
    rs1_addr_in = 5'd0; rs2_addr_in = 5'd0; rd_addr_in = 5'd0; alu_op_in = OP_ADD;
    alu_src_in = 1'b0; pc_src_in = 1'b0; jalr_in = 1'b0; jmp_ctl_in = 1'b0; bch_ctl_in = 1'b0;
    mem_ctl_in = 1'b0; rd_wen_in = 1'b0; wb_ctl_in = 2'd0; byt_typ_in = 3'd0;
    mem_fwd_en = 1'b0; mem_rd = 5'd0; mem_fwd_val = 32'd0;
    wb_fwd_en = 1'b0; wb_rd = 5'd0; wb_fwd_val = 32'd0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b[4:0];
      5'd3:  r = {31'd0, $signed(a) < $signed(b)};
      5'd4:  r = {31'd0, a < b};
      5'd5:  r = a ^ b;
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = {31'd0, a == b};
      5'd11: r = {31'd0, a != b};
      5'd12: r = {31'd0, $signed(a) < $signed(b)};
      5'd13: r = {31'd0, $signed(a) >= $signed(b)};
      5'd14: r = {31'd0, a < b};
      5'd15: r = {31'd0, a >= b};
      5'd16: r = a * b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (op == OP_DIV || op == OP_REM) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return (op == OP_REM || op == OP_REMU) ? r : q;
  endfunction

  task automatic drive_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    clear_inputs();
    alu_op_in = op; rs1_addr_in = 5'd1; rs1_val_in = a; rs2_addr_in = 5'd2; rs2_val_in = b;
    rd_addr_in = 5'd7; rd_wen_in = 1'b1;
    sb_q.push_back('{tag: tag, rslt: ref_alu(op, a, b)});
    step();
    pop_chk();
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int busy_n;
    clear_inputs();
    alu_op_in = op; rs1_addr_in = 5'd1; rs1_val_in = a; rs2_addr_in = 5'd2; rs2_val_in = b;
    rd_addr_in = 5'd9; rd_wen_in = 1'b1;
    sb_q.push_back('{tag: tag, rslt: ref_div(op, a, b)});
    step();
    chk({tag, "_bubble"}, {63'd0, rd_wen_out}, 64'd0);
    clear_inputs();
    alu_src_in = 1'b1; imm_ext_in = 32'h55; rd_wen_in = 1'b1;
    sb_q.push_back('{tag: {tag, "_next"}, rslt: 32'h55});
    busy_n = 0;
    while (ex_busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      step();
    end
    chk({tag, "_busy_cycles"}, busy_n, 64'd32);
    chk({tag, "_done_wen"}, {63'd0, rd_wen_out}, 64'd1);
    pop_chk();
    step();
    pop_chk();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [31:0] a, b;
    logic [4:0] op;
    clear_inputs();
    rst = 1'b1;
    pc_in = 32'h1234; rs2_addr_in = 5'd3; rs2_val_in = 32'hABCD; imm_ext_in = 32'h77;
    mem_ctl_in = 1'b1; rd_wen_in = 1'b1; jmp_ctl_in = 1'b1; wb_ctl_in = 2'd3; rd_addr_in = 5'd4;
    repeat (2) step();
    chk("rst_rslt", {32'd0, rslt_out}, 64'd0);
    chk("rst_tgt", {32'd0, tgt_addr_out}, 64'd0);
    chk("rst_rs2", {32'd0, rs2_val_out}, 64'd0);
    chk("rst_imm", {32'd0, imm_ext_out}, 64'd0);
    chk("rst_ctl", {50'd0, jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out, wb_ctl_out, byt_typ_out, rd_addr_out}, 64'd0);
    chk("rst_busy", {63'd0, ex_busy}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      for (int p = 0; p < 3; p++) begin
        op = 5'(i);
        case (p)
          0: begin a = 32'hFFFF_FFF9; b = 32'h0000_0003; end
          1: begin a = 32'h1234_5678; b = 32'h1234_5678; end
          default: begin a = $urandom; b = $urandom; end
        endcase
        drive_alu(op, a, b, $sformatf("alu%0d_%0d", i, p));
      end
    end

    clear_inputs();
    alu_op_in = OP_SUB; rs1_addr_in = 5'd1; rs1_val_in = 32'd10; alu_src_in = 1'b1;
    imm_ext_in = 32'hFFFF_FFFD; bch_ctl_in = 1'b1; mem_ctl_in = 1'b1; wb_ctl_in = 2'b10;
    byt_typ_in = 3'b101; rd_addr_in = 5'd17; rs2_addr_in = 5'd2; rs2_val_in = 32'h600D;
    sb_q.push_back('{tag: "imm_sub", rslt: 32'd13});
    step(); pop_chk();
    chk("pass_ctl", {55'd0, bch_ctl_out, mem_ctl_out, wb_ctl_out, byt_typ_out, rd_addr_out[1:0]}, {55'd0, 1'b1, 1'b1, 2'b10, 3'b101, 2'b01});
    chk("pass_imm", {32'd0, imm_ext_out}, {32'd0, 32'hFFFF_FFFD});
    chk("pass_rs2", {32'd0, rs2_val_out}, {32'd0, 32'h600D});

    clear_inputs();
    alu_op_in = OP_ADD; pc_src_in = 1'b1; pc_in = 32'h200; rs1_addr_in = 5'd1; rs1_val_in = 32'd99;
    alu_src_in = 1'b1; imm_ext_in = 32'h10;
    sb_q.push_back('{tag: "auipc", rslt: 32'h210});
    step(); pop_chk();

    clear_inputs();
    rs1_addr_in = 5'd1; rs1_val_in = 32'd5; rs2_addr_in = 5'd2; rs2_val_in = 32'd7;
    mem_fwd_en = 1'b1; mem_rd = 5'd1; mem_fwd_val = 32'd100;
    wb_fwd_en = 1'b1; wb_rd = 5'd1; wb_fwd_val = 32'd50;
    sb_q.push_back('{tag: "fwd_mem_prio", rslt: 32'd107});
    step(); pop_chk();

    clear_inputs();
    rs1_addr_in = 5'd1; rs1_val_in = 32'd5; rs2_addr_in = 5'd2; rs2_val_in = 32'd7;
    wb_fwd_en = 1'b1; wb_rd = 5'd2; wb_fwd_val = 32'd50;
    mem_fwd_en = 1'b1; mem_rd = 5'd3; mem_fwd_val = 32'd1000;
    sb_q.push_back('{tag: "fwd_wb_rs2", rslt: 32'd55});
    step(); pop_chk();
    chk("fwd_rs2_out", {32'd0, rs2_val_out}, 64'd50);

    clear_inputs();
    rs1_addr_in = 5'd0; rs1_val_in = 32'd77; mem_fwd_en = 1'b1; mem_rd = 5'd0; mem_fwd_val = 32'd9;
    alu_src_in = 1'b1; imm_ext_in = 32'd3;
    sb_q.push_back('{tag: "fwd_x0", rslt: 32'd3});
    step(); pop_chk();

    clear_inputs();
    pc_in = 32'h40; rs1_addr_in = 5'd1; rs1_val_in = 32'h101; imm_ext_in = 32'd4;
    alu_src_in = 1'b1; jmp_ctl_in = 1'b1; jalr_in = 1'b1; rd_wen_in = 1'b1; rd_addr_in = 5'd1;
    sb_q.push_back('{tag: "jalr_link", rslt: 32'h44});
    step(); pop_chk();
    chk("jalr_tgt", {32'd0, tgt_addr_out}, 64'h104);
    chk("jalr_jmp", {63'd0, jmp_ctl_out}, 64'd1);

    clear_inputs();
    pc_in = 32'h40; imm_ext_in = 32'h20; alu_src_in = 1'b1; jmp_ctl_in = 1'b1;
    sb_q.push_back('{tag: "jal_link", rslt: 32'h44});
    step(); pop_chk();
    chk("jal_tgt", {32'd0, tgt_addr_out}, 64'h60);

    clear_inputs();
    alu_op_in = 5'd12; pc_in = 32'h100; imm_ext_in = 32'hFFFF_FFF8; bch_ctl_in = 1'b1;
    rs1_addr_in = 5'd1; rs1_val_in = 32'hFFFF_FFFF; rs2_addr_in = 5'd2; rs2_val_in = 32'd1;
    sb_q.push_back('{tag: "blt_taken", rslt: 32'd1});
    step(); pop_chk();
    chk("br_tgt", {32'd0, tgt_addr_out}, 64'hF8);

    run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_div(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_div(OP_DIVU, 32'd9, 32'd0, "divu_by0");
    run_div(OP_REMU, 32'd9, 32'd0, "remu_by0");
    run_div(OP_DIV,  32'hFFFF_FFFB, 32'd0, "div_by0_s");
    run_div(OP_REM,  32'hFFFF_FFFB, 32'd0, "rem_by0_s");
    run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_div(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_div(OP_REMU, 32'd100, 32'd7, "remu_100_7");
    for (int k = 0; k < 4; k++) begin
      run_div(OP_DIV + 5'(k), $urandom, 32'($urandom_range(1, 50000)), $sformatf("div_rnd%0d", k));
    end

    clear_inputs();
    alu_op_in = OP_DIV; rs1_addr_in = 5'd1; rs1_val_in = 32'd1000; rs2_addr_in = 5'd2;
    rs2_val_in = 32'd3; rd_wen_in = 1'b1;
    step();
    clear_inputs();
    repeat (10) step();
    chk("fl_busy_pre", {63'd0, ex_busy}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_busy", {63'd0, ex_busy}, 64'd0);
    chk("fl_bubble", {60'd0, jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out}, 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ex_busy !== 1'b0 || rd_wen_out !== 1'b0 || rslt_out !== 32'd0) bad++;
    end
    chk("fl_no_result", bad, 64'd0);

    clear_inputs();
    alu_op_in = OP_DIVU; rs1_addr_in = 5'd1; rs1_val_in = 32'd500; rs2_addr_in = 5'd2;
    rs2_val_in = 32'd4; mem_ctl_in = 1'b1; byt_typ_in = 3'b010; wb_ctl_in = 2'b01;
    pc_in = 32'h80; imm_ext_in = 32'h10; rd_addr_in = 5'd6;
    step();
    chk("sw_div_mem_bubble", {62'd0, mem_ctl_out, ex_busy}, 64'd1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    chk("rst_mid_rslt", {32'd0, rslt_out}, 64'd0);
    chk("rst_mid_tgt", {32'd0, tgt_addr_out}, 64'd0);
    chk("rst_mid_ctl", {51'd0, jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out, wb_ctl_out, byt_typ_out, ex_busy, rd_addr_out}, 64'd0);
    chk("rst_mid_data", {rs2_val_out, imm_ext_out}, 64'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ex_busy !== 1'b0 || rslt_out !== 32'd0) bad++;
    end
    chk("rst_no_result", bad, 64'd0);

    chk("sb_drain", sb_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stage_ex.md
STAGE_EX -- requirements
Module: stage_EX

Interface
REQ-001 Parameters SHALL be, one per line: reg_addr_width, `REG_ADDR_WIDTH, register index width; mem_addr_width, `MEM_ADDR_WIDTH, instruction address width; word_width, `WORD_WIDTH (32), datapath width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports (name  direction  width  meaning): clk  in  1  clock, rising-edge; rst  in  1  synchronous active-high reset.
REQ-003 ID-side inputs SHALL be: pc_in  in  mem_addr_width  instruction PC; rs1_val_in, rs2_val_in  in  word_width  register-file operands; rs1_addr_in, rs2_addr_in, rd_addr_in  in  reg_addr_width  register indices; imm_ext_in  in  word_width  extended immediate; alu_op_in  in  5  operation code; alu_src_in  in  1  B operand = immediate; pc_src_in  in  1  A operand = PC; jalr_in  in  1  register-relative jump.
REQ-004 Pass-through control inputs SHALL be: jmp_ctl_in, bch_ctl_in, mem_ctl_in, rd_wen_in  in  1; wb_ctl_in  in  2; byt_typ_in  in  3.
REQ-005 Forwarding inputs SHALL be: mem_fwd_en  in  1, mem_rd  in  reg_addr_width, mem_fwd_val  in  word_width, from the MEM stage; wb_fwd_en  in  1, wb_rd  in  reg_addr_width, wb_fwd_val  in  word_width, from the write-back stage.
REQ-006 Hazard ports SHALL be: flush  in  1  kill the in-flight instruction; ex_busy  out  1  stall request to IF/ID.
REQ-007 Outputs to MEM SHALL be: tgt_addr_out  mem_addr_width; rs2_val_out, rslt_out, imm_ext_out  word_width; jmp_ctl_out, bch_ctl_out, mem_ctl_out, rd_wen_out  1; wb_ctl_out  2; byt_typ_out  3; rd_addr_out  reg_addr_width. All outputs SHALL be combinational from internal registers.

Function
REQ-008 An internal pipeline register SHALL capture every *_in input on each rising edge while ex_busy=0; while ex_busy=1 it SHALL hold its value.
REQ-009 When flush=1 at an edge, the pipeline register SHALL capture a bubble (rd_wen, mem_ctl, jmp_ctl, bch_ctl = 0; other fields don't-care); flush SHALL override ex_busy and SHALL abort any divide in progress, returning the FSM to IDLE.
REQ-010 Forwarded operand for rsN SHALL be mem_fwd_val if mem_fwd_en and mem_rd==rsN_addr; else wb_fwd_val if wb_fwd_en and wb_rd==rsN_addr; else the latched rsN_val. Index 0 SHALL never be forwarded and SHALL read as 0.
REQ-011 ALU A SHALL be the PC (zero-extended) when pc_src=1, else forwarded rs1; ALU B SHALL be imm_ext when alu_src=1, else forwarded rs2; rs2_val_out SHALL always be forwarded rs2.
REQ-012 Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (shift amount B[4:0]); BEQ, BNE, BLT, BGE, BLTU, BGEU yielding rslt 1/0; MUL yielding low 32 bits of the product. Results SHALL be visible in the cycle after capture.
REQ-013 When jmp_ctl=1, rslt_out SHALL be PC+4 (link value); tgt_addr_out SHALL be (rs1+imm)&~1 if jalr=1, else PC+imm, truncated to mem_addr_width.
REQ-014 DIV, DIVU, REM, REMU SHALL use an iterative one-bit-per-cycle restoring divider with FSM IDLE -> DIV -> DONE -> IDLE; operands SHALL be latched (with sign removed for signed ops) on entering DIV.
REQ-015 DIV SHALL last exactly 32 cycles (counter 0..31); ex_busy SHALL be 1 in every DIV cycle and 0 in DONE, where the signed-corrected result is presented for one cycle.
REQ-016 While in DIV, rd_wen_out, mem_ctl_out, jmp_ctl_out and bch_ctl_out SHALL be 0 (bubble to MEM).
REQ-017 Divide by zero SHALL return quotient all-ones and remainder = dividend; signed 0x80000000 / -1 SHALL return quotient 0x80000000 and remainder 0; both SHALL still take 32 cycles.

Reset
REQ-018 While rst=1 at an edge, the pipeline register SHALL become a bubble with all fields zero, the FSM SHALL enter IDLE, the counter SHALL clear, and every output including ex_busy SHALL be 0 the following cycle; reset SHALL abort a divide mid-operation.

Verification
REQ-019 ADD with rs1=5, rs2=7, mem_fwd_en=1, mem_rd=rs1, mem_fwd_val=100, wb_fwd_en=1, wb_rd=rs1, wb_fwd_val=50 -> rslt_out=107 (MEM priority over WB).
REQ-020 Forwarding with rs1_addr=0, mem_rd=0, mem_fwd_en=1, mem_fwd_val=9, ADD imm=3 -> rslt_out=3.
REQ-021 JALR, pc=0x40, rs1=0x101, imm=4 -> tgt_addr_out=0x104, rslt_out=0x44, jmp_ctl_out=1.
REQ-022 DIV -7/2 -> ex_busy high exactly 32 cycles, then rslt_out=0xFFFFFFFD for one cycle; REM -7/2 -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF.
REQ-023 Flush asserted at DIV cycle 10 -> ex_busy=0 next cycle, bubble on outputs, no result emitted.
REQ-024 rst asserted mid-divide with SW in the register -> next cycle all outputs 0, mem_ctl_out=0, ex_busy=0.
